pc_fetch_seq: RTL

Fetch sequencer for the pipelined MIPS core. It owns the next-fetch PC and drives the instruction-memory request/ack handshake. It handles redirects (exception, eret, jump, branch), decode-stage stall and in-flight squashing. It presents one instruction per cycle to IF/ID, with that instruction's PC, PC+4 and PC+8 (PC+8 is the jal/jalr link value).

---
 rtl/pc_fetch_seq_if.sv | 11 +
 rtl/pc_fetch_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_seq_if.sv
// Instruction-memory request/ack bus between the fetch sequencer and imem.
// The master holds req and addr until ack; ack is a one-cycle pulse with rdata valid.
interface pc_fetch_seq_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: owns the next-fetch PC and the imem handshake, handles
// redirects, decode stall and squashing of in-flight fetches.
module pc_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  input  logic                 jmp,
  input  logic [31:0]          jmp_target,
  input  logic                 exc,
  input  logic                 eret,
  input  logic [31:0]          epc,
  pc_fetch_seq_if.master       imem,
  output logic                 if_valid,
  output logic [31:0]          if_instr,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_pc4,
  output logic [31:0]          if_pc8
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] npc_reg, npc_next;
  logic        req_reg, req_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [31:0] if_pc_reg, if_pc_next;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] sel;
  logic        slot_free;
  logic        launch;

  // Redirect source priority: exc > eret > jmp > branch; targets are word aligned.
  always_comb begin
    redirect = exc | eret | jmp | br_taken;
    if (exc)
      target_raw = EXC_VEC;
    else if (eret)
      target_raw = epc;
    else if (jmp)
      target_raw = jmp_target;
    else
      target_raw = br_target;
  end

  assign target    = target_raw & 32'hFFFF_FFFC;
  assign sel       = redirect ? target : npc_reg;
  assign slot_free = !if_valid_reg || !stall;

  always_comb begin
    state_next     = state_reg;
    npc_next       = npc_reg;
    req_next       = req_reg;
    addr_next      = addr_reg;
    buf_instr_next = buf_instr_reg;
    buf_pc_next    = buf_pc_reg;
    if_instr_next  = if_instr_reg;
    if_pc_next     = if_pc_reg;
    launch         = 1'b0;

    // Decode takes the slot this cycle unless it is refilled below; a redirect squashes it.
    if_valid_next = if_valid_reg && stall && !redirect;

    case (state_reg)
      IDLE: begin
        launch     = 1'b1;
        state_next = REQ;
      end
      REQ: begin
        if (!imem.ack) begin
          if (redirect) begin
            npc_next   = target;
            state_next = DROP;
          end
        end else if (redirect) begin
          launch = 1'b1;
        end else if (slot_free) begin
          if_valid_next = 1'b1;
          if_instr_next = imem.rdata;
          if_pc_next    = addr_reg;
          launch        = 1'b1;
        end else begin
          buf_instr_next = imem.rdata;
          buf_pc_next    = addr_reg;
          req_next       = 1'b0;
          state_next     = HOLD;
        end
      end
      DROP: begin
        if (imem.ack) begin
          launch     = 1'b1;
          state_next = REQ;
        end else if (redirect) begin
          npc_next = target;
        end
      end
      HOLD: begin
        if (redirect) begin
          buf_instr_next = '0;
          buf_pc_next    = '0;
          launch         = 1'b1;
          state_next     = REQ;
        end else if (slot_free) begin
          if_valid_next = 1'b1;
          if_instr_next = buf_instr_reg;
          if_pc_next    = buf_pc_reg;
          launch        = 1'b1;
          state_next    = REQ;
        end
      end
      default: state_next = IDLE;
    endcase

    if (launch) begin
      req_next  = 1'b1;
      addr_next = sel;
      npc_next  = sel + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      npc_reg       <= RESET_PC;
      req_reg       <= 1'b0;
      addr_reg      <= RESET_PC;
      buf_instr_reg <= '0;
      buf_pc_reg    <= '0;
      if_valid_reg  <= 1'b0;
      if_instr_reg  <= '0;
      if_pc_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      npc_reg       <= npc_next;
      req_reg       <= req_next;
      addr_reg      <= addr_next;
      buf_instr_reg <= buf_instr_next;
      buf_pc_reg    <= buf_pc_next;
      if_valid_reg  <= if_valid_next;
      if_instr_reg  <= if_instr_next;
      if_pc_reg     <= if_pc_next;
    end
  end

  assign imem.req  = req_reg;
  assign imem.addr = addr_reg;
  assign if_valid  = if_valid_reg;
  assign if_instr  = if_instr_reg;
  assign if_pc     = if_pc_reg;
  assign if_pc4    = if_pc_reg + 32'd4;
  assign if_pc8    = if_pc_reg + 32'd8;

endmodule
